mbtrain_seq: RTL and testbench
==============================

Name: mbtrain_seq

Overview:
- Parametrised MBTRAIN sequencer for the UCIe LTSM.
- Steps through NUM_STEPS training sub-steps (VALVREF … LINKSPEED, REPAIR), bracketing each with sideband start/end request-response exchanges with the link partner, and launching per-step engines.
- Evaluates per-lane results; degrades lane width or speed and retrains as needed.
- Sits between the LTSM top level and the SB TX/RX message ports, and in front of the per-step MB engines.

Parameters:
- NUM_LANES, 16, number of mainband data lanes (even, ≥2).
- NUM_STEPS, 8, number of training sub-steps, executed in order 0..NUM_STEPS-1.
- STEP_W, 3, width of step id; must satisfy 2**STEP_W ≥ NUM_STEPS.
- MAX_SPEED, 5, initial/highest speed index; index 0 is the lowest speed.
- TIMEOUT_CYCLES, 800000, per-step timeout in clk_100MHz cycles (8 ms).

Ports:
- clk_100MHz  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  level; sequence runs while high.
- done_o  out  1  high while in DONE.
- error_o  out  1  high while in ERROR.
- speed_idx_o  out  3  current speed index.
- lane_mask_o  out  NUM_LANES  active lanes; 1 = lane in use.
- step_start_o  out  1  one-cycle pulse that launches the step engine.
- step_id_o  out  STEP_W  current step.
- step_done_i  in  1  one-cycle pulse from the step engine.
- step_lane_err_i  in  NUM_LANES  per-lane fail flags; valid with step_done_i.
- sb_tx_valid_o  out  1  SB message valid.
- sb_tx_type_o  out  2  0=START_REQ, 1=START_RESP, 2=END_REQ, 3=END_RESP.
- sb_tx_step_o  out  STEP_W  step id carried in the message.
- sb_tx_next_i  in  1  SB TX accepted message (sendNextFlag).
- sb_rx_req_o  out  1  ready to consume an RX message.
- sb_rx_valid_i  in  1  RX message present.
- sb_rx_type_i  in  2  RX message type.
- sb_rx_step_i  in  STEP_W  RX message step id.
- timeout_rst_o  out  1  one-cycle pulse on every step entry; resets the LTSM state timeout.

Behaviour:
- Reset values:
  - All outputs 0, except speed_idx_o=MAX_SPEED and lane_mask_o=all ones.
  - State IDLE, step=0.
- States: IDLE, START_SYNC, RUN, END_SYNC, EVAL, DONE, ERROR.
- IDLE → START_SYNC on enable_i=1. step=0, timeout_rst_o pulses.
- TX handshake:
  - sb_tx_valid_o, type and step are held stable until the cycle sb_tx_next_i=1.
  - Valid drops the following cycle; at most one message is outstanding.
- RX handshake:
  - sb_rx_req_o=1 in START_SYNC and END_SYNC.
  - A message is consumed in the cycle sb_rx_valid_i && sb_rx_req_o.
  - Messages whose step ≠ current step, or whose type is illegal for the state, are consumed and dropped.
- START_SYNC:
  - Send START_REQ.
  - On RX START_REQ, set rx_req_seen and queue a START_RESP, sent after our REQ.
  - On RX START_RESP, set resp_seen.
  - Exit to RUN when rx_req_seen, resp_seen and our RESP are all accepted.
  - RX messages may arrive in any order, including in the same cycle as a TX accept.
- RUN:
  - step_start_o pulses on the first RUN cycle.
  - Wait for step_done_i; latch step_lane_err_i & lane_mask_o (errors on inactive lanes are ignored).
- END_SYNC: same as START_SYNC, using END_REQ/END_RESP. Then go to EVAL.
- EVAL (1 cycle):
  - Masked errors == 0: if step==NUM_STEPS-1 go to DONE, else step+1 and START_SYNC (timeout_rst_o pulse).
  - Errors ≠ 0 (lane repair per Optional Feature): speed degrade.
    - If speed_idx>0: speed_idx-1, lane_mask=all ones, step=0, START_SYNC.
    - If speed_idx==0: go to ERROR.
- Timeout:
  - Counter clears on each step entry and counts in START_SYNC, RUN and END_SYNC.
  - Reaching TIMEOUT_CYCLES-1 → ERROR, with priority over any other transition that cycle.
- DONE and ERROR are sticky until enable_i=0.
- enable_i=0 in any state → IDLE next cycle:
  - sb_tx_valid_o drops immediately (combinational gating).
  - speed and mask restored to reset values; any pending step_done_i is ignored.

Optional Feature:
- Macro: MBTRAIN_LANE_REPAIR_EN.
- Defined: in EVAL, with lane_mask all ones and masked errors ≠ 0:
  - Errors only in upper half → mask = lower half ones, step=0, retry at same speed.
  - Errors only in lower half → mask = upper half ones, step=0, retry at same speed.
  - Otherwise, or if the mask is already halved → speed degrade as above.
- Not defined: any masked error → speed degrade; lane_mask_o is constantly all ones.

Test Plan:
- Clean run, NUM_STEPS=8, partner mirrors every REQ/RESP, step_lane_err_i=0 → done_o=1, speed_idx_o=5, lane_mask_o=16'hFFFF; exactly 8 step_start_o pulses and 32 TX messages.
- Partner sends START_RESP before START_REQ; sb_tx_next_i delayed 5 cycles → sb_tx_valid_o and type held stable for 5 cycles; RUN is reached only after both RX messages are received.
- Step 3 reports lane_err=16'h0001 once → speed_idx_o=4, mask 16'hFFFF, step restarts at 0; clean thereafter → done_o=1.
- With MBTRAIN_LANE_REPAIR_EN, step 2 lane_err=16'h0F00 → lane_mask_o=16'h00FF, speed stays 5. A later error on lane 0 → speed 4, mask 16'hFFFF.
- Speed at 0 and any lane error → error_o=1 and sticky. enable_i low → IDLE, speed_idx_o=5, error_o=0.
- TIMEOUT_CYCLES=20, partner silent in START_SYNC → error_o=1 exactly 20 cycles after step entry.

Source files
------------

// File: rtl/mbtrain_seq_if.sv
// mbtrain_seq_if: sideband TX/RX message ports plus step-engine launch/return
// between the MBTRAIN sequencer (master) and its partners (slave).
interface mbtrain_seq_if #(
    parameter int NUM_LANES = 16,
    parameter int STEP_W    = 3
);
    logic                 step_start_o;
    logic [STEP_W-1:0]    step_id_o;
    logic                 step_done_i;
    logic [NUM_LANES-1:0] step_lane_err_i;
    logic                 sb_tx_valid_o;
    logic [1:0]           sb_tx_type_o;
    logic [STEP_W-1:0]    sb_tx_step_o;
    logic                 sb_tx_next_i;
    logic                 sb_rx_req_o;
    logic                 sb_rx_valid_i;
    logic [1:0]           sb_rx_type_i;
    logic [STEP_W-1:0]    sb_rx_step_i;

    modport master (
        output step_start_o, step_id_o, sb_tx_valid_o, sb_tx_type_o, sb_tx_step_o, sb_rx_req_o,
        input  step_done_i, step_lane_err_i, sb_tx_next_i, sb_rx_valid_i, sb_rx_type_i, sb_rx_step_i
    );
    modport slave (
        input  step_start_o, step_id_o, sb_tx_valid_o, sb_tx_type_o, sb_tx_step_o, sb_rx_req_o,
        output step_done_i, step_lane_err_i, sb_tx_next_i, sb_rx_valid_i, sb_rx_type_i, sb_rx_step_i
    );
endinterface

// File: rtl/mbtrain_seq.sv
// mbtrain_seq: UCIe LTSM MBTRAIN sub-step sequencer with SB start/end handshakes.
// Define MBTRAIN_LANE_REPAIR_EN to halve lane width before degrading speed.
module mbtrain_seq #(
    parameter int NUM_LANES      = 16,
    parameter int NUM_STEPS      = 8,
    parameter int STEP_W         = 3,
    parameter int MAX_SPEED      = 5,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 enable_i,
    output logic                 done_o,
    output logic                 error_o,
    output logic [2:0]           speed_idx_o,
    output logic [NUM_LANES-1:0] lane_mask_o,
    output logic                 timeout_rst_o,
    mbtrain_seq_if.master        bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_START_SYNC = 3'd1, S_RUN = 3'd2, S_END_SYNC = 3'd3,
                           S_EVAL = 3'd4, S_DONE = 3'd5, S_ERROR = 3'd6;
    localparam logic [1:0] M_START_REQ = 2'd0, M_END_REQ = 2'd2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [NUM_LANES-1:0] ALL_ONES = '1;
`ifdef MBTRAIN_LANE_REPAIR_EN
    localparam int HALF = NUM_LANES / 2;
    localparam logic [NUM_LANES-1:0] LO_HALF = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [NUM_LANES-1:0] HI_HALF = {{HALF{1'b1}}, {HALF{1'b0}}};
`endif

    logic [2:0]           state;
    logic [STEP_W-1:0]    step;
    logic [TW-1:0]        tmo_cnt;
    logic                 tx_valid, step_start;
    logic [1:0]           tx_type;
    logic                 req_sent, resp_sent, rx_req_seen, resp_seen;
    logic [NUM_LANES-1:0] lane_err, mask, repair_mask;
    logic [2:0]           speed;
    logic                 in_sync, is_end, tx_acc, rx_take, sync_ok, tmo_hit, repair, go_start;

    assign in_sync = (state == S_START_SYNC) || (state == S_END_SYNC);
    assign is_end  = (state == S_END_SYNC);
    assign tx_acc  = tx_valid && bus.sb_tx_next_i;
    assign rx_take = in_sync && bus.sb_rx_valid_i && (bus.sb_rx_step_i == step);
    assign sync_ok = rx_req_seen && resp_seen && resp_sent;
    assign tmo_hit = (in_sync || state == S_RUN) && (tmo_cnt == TMO_LAST);

    // Only consulted when masked errors are non-zero, so "no low-half error" means upper-only.
    always_comb begin
        repair      = 1'b0;
        repair_mask = ALL_ONES;
`ifdef MBTRAIN_LANE_REPAIR_EN
        if (mask == ALL_ONES) begin
            if ((lane_err & LO_HALF) == '0) begin
                repair      = 1'b1;
                repair_mask = LO_HALF;
            end else if ((lane_err & HI_HALF) == '0) begin
                repair      = 1'b1;
                repair_mask = HI_HALF;
            end
        end
`endif
    end

    always_comb begin
        go_start = 1'b0;
        if (state == S_IDLE)
            go_start = 1'b1;
        else if (state == S_EVAL)
            go_start = (lane_err == '0) ? (step != LAST_STEP) : (repair || speed != 3'd0);
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;  step <= '0;  tmo_cnt <= '0;
            tx_valid <= 1'b0;  tx_type <= M_START_REQ;  step_start <= 1'b0;  timeout_rst_o <= 1'b0;
            req_sent <= 1'b0;  resp_sent <= 1'b0;  rx_req_seen <= 1'b0;  resp_seen <= 1'b0;
            lane_err <= '0;  mask <= ALL_ONES;  speed <= 3'(MAX_SPEED);
        end else if (!enable_i) begin
            state <= S_IDLE;  step <= '0;  tmo_cnt <= '0;
            tx_valid <= 1'b0;  tx_type <= M_START_REQ;  step_start <= 1'b0;  timeout_rst_o <= 1'b0;
            req_sent <= 1'b0;  resp_sent <= 1'b0;  rx_req_seen <= 1'b0;  resp_seen <= 1'b0;
            lane_err <= '0;  mask <= ALL_ONES;  speed <= 3'(MAX_SPEED);
        end else begin
            timeout_rst_o <= 1'b0;
            step_start    <= 1'b0;
            if (in_sync || state == S_RUN) tmo_cnt <= tmo_cnt + 1'b1;
            // Our RESP goes out only after our REQ was accepted and the partner's REQ was seen.
            if (in_sync) begin
                if (tx_acc) begin
                    tx_valid <= 1'b0;
                    if (tx_type[0]) resp_sent <= 1'b1;
                    else            req_sent  <= 1'b1;
                end else if (!tx_valid && req_sent && rx_req_seen && !resp_sent) begin
                    tx_valid <= 1'b1;
                    tx_type  <= {is_end, 1'b1};
                end
                if (rx_take && bus.sb_rx_type_i == {is_end, 1'b0}) rx_req_seen <= 1'b1;
                if (rx_take && bus.sb_rx_type_i == {is_end, 1'b1}) resp_seen   <= 1'b1;
            end
            if (tmo_hit) begin
                state    <= S_ERROR;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    S_START_SYNC: if (sync_ok) begin
                        state      <= S_RUN;
                        step_start <= 1'b1;
                    end
                    S_RUN: if (bus.step_done_i) begin
                        lane_err <= bus.step_lane_err_i & mask;
                        state    <= S_END_SYNC;
                        tx_valid <= 1'b1;
                        tx_type  <= M_END_REQ;
                        req_sent <= 1'b0;  resp_sent <= 1'b0;  rx_req_seen <= 1'b0;  resp_seen <= 1'b0;
                    end
                    S_END_SYNC: if (sync_ok) state <= S_EVAL;
                    S_EVAL: begin
                        if (lane_err == '0) begin
                            if (step == LAST_STEP) state <= S_DONE;
                            else                   step  <= step + 1'b1;
                        end else if (repair) begin
                            mask <= repair_mask;
                            step <= '0;
                        end else if (speed != 3'd0) begin
                            speed <= speed - 1'b1;
                            mask  <= ALL_ONES;
                            step  <= '0;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                    default: ;
                endcase
                if (go_start) begin
                    state         <= S_START_SYNC;
                    tmo_cnt       <= '0;
                    timeout_rst_o <= 1'b1;
                    tx_valid      <= 1'b1;
                    tx_type       <= M_START_REQ;
                    req_sent <= 1'b0;  resp_sent <= 1'b0;  rx_req_seen <= 1'b0;  resp_seen <= 1'b0;
                end
            end
        end
    end

    assign done_o            = (state == S_DONE);
    assign error_o           = (state == S_ERROR);
    assign speed_idx_o       = speed;
    assign lane_mask_o       = mask;
    assign bus.step_start_o  = step_start;
    assign bus.step_id_o     = step;
    assign bus.sb_tx_valid_o = tx_valid && enable_i;
    assign bus.sb_tx_type_o  = tx_type;
    assign bus.sb_tx_step_o  = step;
    assign bus.sb_rx_req_o   = in_sync;
endmodule

// File: tb/tb_mbtrain_seq.sv
// tb_mbtrain_seq: table-driven training runs against a mirroring partner model,
// plus hand-driven handshake, enable-gating and timeout sequences.
`timescale 1ns/1ps
module tb_mbtrain_seq;
    localparam int NL = 16;
    localparam int NS = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable, en2;
    logic          done, error, trst, done2, error2, trst2;
    logic [2:0]    speed, speed2;
    logic [NL-1:0] mask, mask2;

    mbtrain_seq_if #(.NUM_LANES(NL), .STEP_W(SW)) bus ();
    mbtrain_seq_if #(.NUM_LANES(NL), .STEP_W(SW)) bus2 ();

    mbtrain_seq #(.NUM_LANES(NL), .NUM_STEPS(NS), .STEP_W(SW), .MAX_SPEED(5), .TIMEOUT_CYCLES(800000)) dut (
        .clk_100MHz(clk), .reset(rst_n), .enable_i(enable), .done_o(done), .error_o(error),
        .speed_idx_o(speed), .lane_mask_o(mask), .timeout_rst_o(trst), .bus(bus));

    mbtrain_seq #(.NUM_LANES(NL), .NUM_STEPS(NS), .STEP_W(SW), .MAX_SPEED(5), .TIMEOUT_CYCLES(20)) dut2 (
        .clk_100MHz(clk), .reset(rst_n), .enable_i(en2), .done_o(done2), .error_o(error2),
        .speed_idx_o(speed2), .lane_mask_o(mask2), .timeout_rst_o(trst2), .bus(bus2));

    // Silent partner for the timeout instance.
    assign bus2.sb_tx_next_i    = 1'b0;
    assign bus2.sb_rx_valid_i   = 1'b0;
    assign bus2.sb_rx_type_i    = 2'd0;
    assign bus2.sb_rx_step_i    = '0;
    assign bus2.step_done_i     = 1'b0;
    assign bus2.step_lane_err_i = '0;

    // Automatic partner (a_*) or hand-driven (m_*) inputs for the main instance.
    logic          a_next, a_rx_valid, a_done;
    logic [1:0]    a_rx_type;
    logic [SW-1:0] a_rx_step;
    logic [NL-1:0] a_err;
    logic          m_next, m_rx_valid;
    logic [1:0]    m_rx_type;
    logic [SW-1:0] m_rx_step;
    bit            auto_mode;

    assign bus.sb_tx_next_i    = auto_mode ? a_next     : m_next;
    assign bus.sb_rx_valid_i   = auto_mode ? a_rx_valid : m_rx_valid;
    assign bus.sb_rx_type_i    = auto_mode ? a_rx_type  : m_rx_type;
    assign bus.sb_rx_step_i    = auto_mode ? a_rx_step  : m_rx_step;
    assign bus.step_done_i     = auto_mode && a_done;
    assign bus.step_lane_err_i = a_err;

    typedef struct packed { logic [1:0] t; logic [SW-1:0] s; } msg_t;

    typedef struct {
        int a_step; logic [NL-1:0] a_val;
        int b_step; logic [NL-1:0] b_val;
        bit always_a;
        bit e_done; bit e_err; logic [2:0] e_speed; logic [NL-1:0] e_mask; int e_starts; int e_tx;
    } row_t;

    int checks = 0, errors = 0;
    int n_starts = 0, n_tx = 0;
    int a_step = -1, b_step = -1;
    logic [NL-1:0] a_val = '0, b_val = '0;
    bit always_a = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Partner: mirrors each accepted REQ with its own REQ + RESP; step engine answers 3 cycles after start.
    initial begin
        msg_t m, q_req, q_resp;
        msg_t rxq[$];
        int tx_wait, eng_cnt, phase;
        tx_wait = 0; eng_cnt = 0; phase = 0;
        a_next = 0; a_rx_valid = 0; a_rx_type = 0; a_rx_step = 0; a_done = 0; a_err = '0;
        forever begin
            @(negedge clk);
            a_done = 0;
            a_err  = '0;
            if (!enable || !auto_mode) begin
                rxq.delete(); eng_cnt = 0; tx_wait = 0; phase = 0;
                a_next = 0; a_rx_valid = 0;
            end else begin
                a_rx_valid = 0;
                if (bus.sb_rx_req_o && rxq.size() > 0) begin
                    m = rxq.pop_front();
                    a_rx_valid = 1; a_rx_type = m.t; a_rx_step = m.s;
                end
                a_next = 0;
                if (bus.sb_tx_valid_o) begin
                    a_next = 1; tx_wait = 0; n_tx++;
                    if (!bus.sb_tx_type_o[0]) begin
                        q_req  = '{t: bus.sb_tx_type_o, s: bus.sb_tx_step_o};
                        q_resp = '{t: bus.sb_tx_type_o | 2'b01, s: bus.sb_tx_step_o};
                        rxq.push_back(q_req);
                        rxq.push_back(q_resp);
                    end
                end
                if (eng_cnt == 1) begin
                    a_done = 1;
                    if (phase == 0 && a_step == int'(bus.step_id_o)) begin
                        a_err = a_val;
                        if (!always_a) phase = 1;
                    end else if (phase == 1 && b_step == int'(bus.step_id_o)) begin
                        a_err = b_val;
                        phase = 2;
                    end
                end
                if (eng_cnt > 0) eng_cnt--;
                if (bus.step_start_o) begin n_starts++; eng_cnt = 3; end
            end
        end
    end

    task automatic run_row(input row_t r, input int idx);
        int s0, t0;
        bit fin;
        @(negedge clk); enable = 0;
        @(negedge clk);
        @(negedge clk);
        a_step = r.a_step; a_val = r.a_val; b_step = r.b_step; b_val = r.b_val; always_a = r.always_a;
        s0 = n_starts; t0 = n_tx;
        enable = 1;
        fin = 0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(negedge clk);
            if (done || error) fin = 1;
        end
        chk($sformatf("row%0d_finished", idx), 32'(fin), 32'd1);
        chk($sformatf("row%0d_done", idx), 32'(done), 32'(r.e_done));
        chk($sformatf("row%0d_error", idx), 32'(error), 32'(r.e_err));
        chk($sformatf("row%0d_speed", idx), 32'(speed), 32'(r.e_speed));
        chk($sformatf("row%0d_mask", idx), 32'(mask), 32'(r.e_mask));
        chk($sformatf("row%0d_starts", idx), 32'(n_starts - s0), 32'(r.e_starts));
        chk($sformatf("row%0d_tx_msgs", idx), 32'(n_tx - t0), 32'(r.e_tx));
    endtask

    task automatic drv_rx(input logic v, input logic [1:0] t, input logic [SW-1:0] s);
        m_rx_valid = v; m_rx_type = t; m_rx_step = s;
    endtask

    row_t rows[7];

    initial begin
        rows[0] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5, 16'hFFFF, 8, 32};
        rows[4] = '{0, 16'h0101, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd4, 16'hFFFF, 9, 36};
        rows[6] = '{0, 16'h0101, -1, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFF, 6, 24};
`ifdef MBTRAIN_LANE_REPAIR_EN
        rows[1] = '{3, 16'h0001, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5, 16'hFF00, 12, 48};
        rows[2] = '{2, 16'h0F00, 5, 16'h0001, 1'b0, 1'b1, 1'b0, 3'd4, 16'hFFFF, 17, 68};
        rows[3] = '{1, 16'h00F0, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd5, 16'hFF00, 10, 40};
        rows[5] = '{0, 16'h8000, 4, 16'hFF00, 1'b0, 1'b1, 1'b0, 3'd5, 16'h00FF, 9, 36};
`else
        rows[1] = '{3, 16'h0001, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd4, 16'hFFFF, 12, 48};
        rows[2] = '{2, 16'h0F00, 5, 16'h0001, 1'b0, 1'b1, 1'b0, 3'd3, 16'hFFFF, 17, 68};
        rows[3] = '{1, 16'h00F0, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd4, 16'hFFFF, 10, 40};
        rows[5] = '{0, 16'h8000, 4, 16'hFF00, 1'b0, 1'b1, 1'b0, 3'd3, 16'hFFFF, 14, 56};
`endif

        rst_n = 0; enable = 0; en2 = 0; auto_mode = 1;
        m_next = 0; drv_rx(0, 2'd0, '0);
        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_speed", 32'(speed), 32'd5);
        chk("rst_mask", 32'(mask), 32'hFFFF);
        chk("rst_tx_valid", 32'(bus.sb_tx_valid_o), 32'd0);
        chk("rst_rx_req", 32'(bus.sb_rx_req_o), 32'd0);
        chk("rst_step_start", 32'(bus.step_start_o), 32'd0);
        chk("rst_timeout_rst", 32'(trst), 32'd0);
        chk("rst_step_id", 32'(bus.step_id_o), 32'd0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 7; i++) run_row(rows[i], i);

        // Last row ended in ERROR at speed 0: sticky, then enable low restores IDLE.
        repeat (10) @(negedge clk);
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_no_done", 32'(done), 32'd0);
        enable = 0;
        @(negedge clk);
        chk("idle_error_clr", 32'(error), 32'd0);
        chk("idle_speed", 32'(speed), 32'd5);
        chk("idle_mask", 32'(mask), 32'hFFFF);
        chk("idle_rx_req", 32'(bus.sb_rx_req_o), 32'd0);

        // Hand-driven START_SYNC: partner RESP first, stale/illegal RX dropped, TX accept delayed 5 cycles.
        auto_mode = 0;
        @(negedge clk);
        enable = 1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("hold_req_c%0d", c),
                32'({bus.sb_tx_valid_o, bus.sb_tx_type_o, bus.sb_tx_step_o}), 32'({1'b1, 2'd0, 3'd0}));
            if (c == 1) chk("entry_timeout_rst", 32'(trst), 32'd1);
            if (c == 2) chk("timeout_rst_pulse", 32'(trst), 32'd0);
            case (c)
                1: drv_rx(1, 2'd1, 3'd0);
                2: drv_rx(1, 2'd0, 3'd3);
                3: drv_rx(1, 2'd2, 3'd0);
                default: drv_rx(0, 2'd0, 3'd0);
            endcase
            m_next = (c == 6);
        end
        @(negedge clk); m_next = 0;
        chk("req_valid_drop", 32'(bus.sb_tx_valid_o), 32'd0);
        @(negedge clk);
        chk("no_resp_before_rx_req", 32'(bus.sb_tx_valid_o), 32'd0);
        drv_rx(1, 2'd0, 3'd0);
        @(negedge clk);
        drv_rx(0, 2'd0, 3'd0);
        chk("resp_gap", 32'(bus.sb_tx_valid_o), 32'd0);
        @(negedge clk);
        chk("resp_sent", 32'({bus.sb_tx_valid_o, bus.sb_tx_type_o}), 32'({1'b1, 2'd1}));
        m_next = 1;
        @(negedge clk); m_next = 0;
        chk("resp_valid_drop", 32'(bus.sb_tx_valid_o), 32'd0);
        chk("still_sync_start", 32'(bus.step_start_o), 32'd0);
        chk("still_sync_rx_req", 32'(bus.sb_rx_req_o), 32'd1);
        @(negedge clk);
        chk("run_step_start", 32'(bus.step_start_o), 32'd1);
        chk("run_rx_req", 32'(bus.sb_rx_req_o), 32'd0);

        // Enable low gates TX valid combinationally.
        enable = 0;
        repeat (2) @(negedge clk);
        enable = 1;
        @(negedge clk);
        chk("gate_valid_before", 32'(bus.sb_tx_valid_o), 32'd1);
        enable = 0;
        #1;
        chk("gate_valid_comb", 32'(bus.sb_tx_valid_o), 32'd0);
        @(negedge clk);
        chk("gate_idle_rx_req", 32'(bus.sb_rx_req_o), 32'd0);

        // Timeout instance: silent partner, error exactly 20 cycles after step entry.
        en2 = 1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1)  chk("tmo_entry_pulse", 32'(trst2), 32'd1);
            if (c == 20) chk("tmo_not_yet", 32'(error2), 32'd0);
            if (c == 20) chk("tmo_req_held", 32'(bus2.sb_tx_valid_o), 32'd1);
            if (c == 21) chk("tmo_error", 32'(error2), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
